irq_ctrl: RTL and testbench
===========================

# irq_ctrl

- Interrupt controller between the memory-mapped peripherals on the MEM stage and the pipeline's hazard logic.
- Collects NSRC interrupt sources, latches them as pending, applies a per-source mask and a global enable, and drives the single `irq` line that the hazard unit uses to flush and redirect.
- Holds off further interrupts until the handler returns.
- Exposes enable, pending and cause registers on the MEM-stage peripheral bus.

## Interface
Parameters:
- NSRC, 4, number of interrupt sources (1..8); source 0 has highest priority
- BASE, 32'h40000030, byte address of the ENABLE register; PEND at BASE+4, CAUSE at BASE+8

Ports:
- clk  in  1  CPU clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- src  in  NSRC  interrupt requests from peripherals (timer, UART rx, UART tx, …), synchronous to clk
- irq  out  1  interrupt request to the hazard unit
- irq_taken  in  1  one-cycle pulse from ID: the pipeline accepted the interrupt this cycle
- eret  in  1  one-cycle pulse from ID: handler return executed
- addr  in  32  MEM-stage byte address
- wr  in  1  MEM-stage write strobe
- rd  in  1  MEM-stage read strobe
- wdata  in  32  write data
- rdata  out  32  read data; combinational from addr/rd; 0 when not selected or rd=0
- in_service  out  1  handler active (for monitor/debug)

## Operation
Registers (all reset to 0):
- ENABLE [NSRC-1:0] per-source mask, bit 31 global enable; read/write.
- PEND [NSRC-1:0] pending; read-only except write-1-to-clear.
- CAUSE [2:0] index of the source latched at take; read-only.

Pending logic:
- A source event sets `PEND[i]` on the next clk edge.
- If a W1C write to bit i coincides with a new event on i, the set wins.
- PEND is independent of ENABLE: masked sources still record pending.

Candidate selection:
- cand = PEND & ENABLE[NSRC-1:0], valid only when ENABLE[31]=1.
- winner = lowest set index of cand.

State machine `st`:
- IDLE: irq=0. If cand≠0, go to ASSERT.
- ASSERT: irq=1. Hold irq until irq_taken.
  - On irq_taken: CAUSE←winner index, clear PEND[winner], go to SERVICE.
  - If cand becomes 0 (mask write or W1C), go to IDLE with irq=0 that cycle (irq is combinational from st and cand).
  - eret is ignored.
- SERVICE: irq=0, in_service=1. New events keep accumulating in PEND.
  - On eret, go to IDLE; a still-pending candidate re-enters ASSERT the following cycle.
  - irq_taken is ignored.

Other rules:
- irq_taken is ignored whenever irq=0.
- Register writes take effect on the clk edge where wr=1 and addr matches. Unmatched addresses are ignored.
- Reset mid-operation returns to IDLE with all registers cleared and irq=0 immediately (asynchronous).

## Timing
- src high at edge N: PEND set at N+1, ASSERT entered at N+2, irq high during cycle N+2.
- irq_taken sampled at edge M: PEND bit cleared, CAUSE written, SERVICE entered, all at M+1. irq is low from M+1.
- eret at edge K: IDLE at K+1. With another candidate pending, irq is high again from K+2.
- rdata for a PEND read reflects the register value before the current edge's updates.
- Reset values: irq=0, in_service=0, rdata=0, ENABLE=PEND=CAUSE=0, st=IDLE.

## Configuration
- `IRQ_EDGE_EN` defined: a source event is a rising edge of src[i], detected against a registered copy. This adds one cycle: PEND sets at N+2 for src rising before edge N+1.
- Undefined: level-sensitive. PEND[i] is set every cycle src[i]=1, so clearing is effective only once the source deasserts.

## Test plan
- Reset, ENABLE=0x80000001, pulse src[0] → PEND=0x1; irq high 2 cycles later (3 with IRQ_EDGE_EN); irq_taken → CAUSE=0, PEND=0, irq low, in_service=1.
- Simultaneous src[1] and src[2], ENABLE=0x80000006 → first take gives CAUSE=1. After eret, irq reasserts within 2 cycles; second take gives CAUSE=2.
- Global enable off, ENABLE=0x00000001, pulse src[0] → PEND=0x1, irq stays 0. Write ENABLE=0x80000001 → irq rises 1 cycle later.
- During ASSERT, W1C write PEND=0x1 → irq drops the same cycle and st returns to IDLE. W1C coincident with a new src[0] event → PEND stays 1.
- src[3] pulses during SERVICE → no irq until eret. irq_taken pulsed in SERVICE has no effect.
- Assert reset while in SERVICE with PEND=0xF → all outputs and registers 0 immediately; no irq after release until a new event.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with memory-mapped ENABLE / PEND / CAUSE registers.
// Define IRQ_EDGE_EN for rising-edge source detection; the default build is level-sensitive.
module irq_ctrl #(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    input  logic            irq_taken,
    input  logic            eret,
    input  logic [31:0]     addr,
    input  logic            wr,
    input  logic            rd,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            in_service
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} st_t;

    st_t             st, st_next;
    logic [NSRC-1:0] en_mask, pend, cand, events, take_clr, w1c;
    logic            glob_en;
    logic [2:0]      cause, winner;
    logic            take;
    logic            sel_en, sel_pend, sel_cause;
    logic            unused_wdata;

    assign sel_en    = (addr == BASE);
    assign sel_pend  = (addr == BASE + 32'd4);
    assign sel_cause = (addr == BASE + 32'd8);

    assign unused_wdata = ^wdata[30:NSRC];

`ifdef IRQ_EDGE_EN
    // Two-stage copy: src_d is the sampled request, src_q its previous value.
    logic [NSRC-1:0] src_d, src_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d <= '0;
            src_q <= '0;
        end else begin
            src_d <= src;
            src_q <= src_d;
        end
    end

    assign events = src_d & ~src_q;
`else
    assign events = src;
`endif

    assign cand = glob_en ? (pend & en_mask) : '0;

    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) winner = 3'(i);
        end
    end

    assign irq        = (st == ASSERT) && (cand != '0);
    assign take       = irq && irq_taken;
    assign in_service = (st == SERVICE);
    assign w1c        = (wr && sel_pend) ? wdata[NSRC-1:0] : '0;

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            take_clr[i] = take && (winner == 3'(i));
        end
    end

    // A new event on a bit overrides any clear on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~w1c & ~take_clr) | events;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_mask <= '0;
            glob_en <= 1'b0;
            cause   <= '0;
        end else begin
            if (wr && sel_en) begin
                en_mask <= wdata[NSRC-1:0];
                glob_en <= wdata[31];
            end
            if (take) cause <= winner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= st_next;
    end

    always_comb begin
        st_next = st;
        case (st)
            IDLE:    if (cand != '0) st_next = ASSERT;
            ASSERT: begin
                if (take)              st_next = SERVICE;
                else if (cand == '0)   st_next = IDLE;
            end
            SERVICE: if (eret) st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_en)         rdata = {glob_en, {(31-NSRC){1'b0}}, en_mask};
            else if (sel_pend)  rdata = {{(32-NSRC){1'b0}}, pend};
            else if (sel_cause) rdata = {29'd0, cause};
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan walk followed by random traffic, both checked against a
// cycle-level behavioural model of pending/enable/handler rules.
module tb_irq_ctrl;

    localparam int          NSRC    = 4;
    localparam logic [31:0] BASE    = 32'h40000030;
    localparam logic [31:0] A_EN    = BASE;
    localparam logic [31:0] A_PEND  = BASE + 32'd4;
    localparam logic [31:0] A_CAUSE = BASE + 32'd8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            irq, irq_taken, eret, wr, rd, in_service;
    logic [31:0]     addr, wdata, rdata;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .src(src), .irq(irq), .irq_taken(irq_taken),
        .eret(eret), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
        .rdata(rdata), .in_service(in_service)
    );

    // Model: mode 0 = waiting, 1 = requesting the pipeline, 2 = handler running.
    bit m_pend[NSRC];
    bit m_mask[NSRC];
    bit m_s1[NSRC];
    bit m_s2[NSRC];
    bit m_gen;
    int m_cause;
    int m_mode;

    function automatic void model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_gen = 0; m_cause = 0; m_mode = 0;
    endfunction

    function automatic int model_winner();
        for (int i = 0; i < NSRC; i++)
            if (m_gen && m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic logic model_irq();
        return (m_mode == 1) && (model_winner() >= 0);
    endfunction

    function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        if (r) begin
            if (a == A_EN) begin
                v[31] = m_gen;
                for (int i = 0; i < NSRC; i++) v[i] = m_mask[i];
            end else if (a == A_PEND) begin
                for (int i = 0; i < NSRC; i++) v[i] = m_pend[i];
            end else if (a == A_CAUSE) begin
                v = 32'(m_cause);
            end
        end
        return v;
    endfunction

    function automatic void model_step(input logic [NSRC-1:0] s, input logic t, input logic e,
                                       input logic w, input logic [31:0] a, input logic [31:0] d);
        int  win;
        bit  take, ev;
        bit  nxt[NSRC];
        win  = model_winner();
        take = (m_mode == 1) && (win >= 0) && t;
        for (int i = 0; i < NSRC; i++) begin
`ifdef IRQ_EDGE_EN
            ev = m_s1[i] && !m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = s[i];
`else
            ev = s[i];
`endif
            nxt[i] = m_pend[i];
            if (w && a == A_PEND && d[i]) nxt[i] = 0;
            if (take && i == win)         nxt[i] = 0;
            if (ev)                       nxt[i] = 1;
        end
        case (m_mode)
            0: if (win >= 0) m_mode = 1;
            1: if (take) m_mode = 2; else if (win < 0) m_mode = 0;
            default: if (e) m_mode = 0;
        endcase
        if (take) m_cause = win;
        if (w && a == A_EN) begin
            m_gen = d[31];
            for (int i = 0; i < NSRC; i++) m_mask[i] = d[i];
        end
        for (int i = 0; i < NSRC; i++) m_pend[i] = nxt[i];
    endfunction

    task automatic checkConst(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkConst("irq", 32'(irq), 32'(model_irq()));
        checkConst("in_service", 32'(in_service), 32'(m_mode == 2));
        checkConst("rdata", rdata, model_rdata(rd, addr));
    endtask

    task automatic applyStimulus(input logic [NSRC-1:0] s, input logic t, input logic e,
                                 input logic w, input logic r, input logic [31:0] a,
                                 input logic [31:0] d);
        #1;
        src = s; irq_taken = t; eret = e; wr = w; rd = r; addr = a; wdata = d;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        model_step(s, t, e, w, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic pulseSrc(input logic [NSRC-1:0] s);
        applyStimulus(s, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        applyStimulus('0, 0, 0, 1, 0, a, d);
    endtask

    task automatic readConst(input string tag, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus('0, 0, 0, 0, 1, a, 32'h0);
        #1;
        checkConst(tag, rdata, exp);
    endtask

    task automatic take();
        applyStimulus('0, 1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic doEret();
        applyStimulus('0, 0, 1, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1; src = '0; irq_taken = 0; eret = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
        model_reset();
        #2;
        checkConst("reset_irq", 32'(irq), 32'h0);
        checkConst("reset_in_service", 32'(in_service), 32'h0);
        rd = 1; addr = A_EN;
        #1 checkConst("reset_enable", rdata, 32'h0);
        rd = 0;
        @(negedge clk);
        reset = 0;

        $display("[TB] single source take");
        writeReg(A_EN, 32'h80000001);
        pulseSrc(4'b0001);
        idle(3);
        #1 checkConst("src0_irq_high", 32'(irq), 32'h1);
        take();
        #1 checkConst("after_take_irq", 32'(irq), 32'h0);
        readConst("cause_src0", A_CAUSE, 32'h0);
        readConst("pend_after_take", A_PEND, 32'h0);
        checkConst("in_service_after_take", 32'(in_service), 32'h1);
        doEret();

        $display("[TB] priority between src1 and src2");
        writeReg(A_EN, 32'h80000006);
        pulseSrc(4'b0110);
        idle(3);
        take();
        readConst("cause_first", A_CAUSE, 32'h1);
        doEret();
        idle(2);
        #1 checkConst("irq_reassert", 32'(irq), 32'h1);
        take();
        readConst("cause_second", A_CAUSE, 32'h2);
        doEret();
        idle(2);

        $display("[TB] global enable gating");
        writeReg(A_EN, 32'h00000001);
        pulseSrc(4'b0001);
        idle(3);
        readConst("pend_masked_global", A_PEND, 32'h1);
        checkConst("irq_global_off", 32'(irq), 32'h0);
        writeReg(A_EN, 32'h80000001);
        idle(1);
        #1 checkConst("irq_global_on", 32'(irq), 32'h1);

        $display("[TB] W1C during ASSERT");
        writeReg(A_PEND, 32'h1);
        #1 checkConst("irq_drop_w1c", 32'(irq), 32'h0);
        applyStimulus(4'b0001, 0, 0, 1, 0, A_PEND, 32'h1);
        idle(2);
        readConst("pend_set_wins", A_PEND, 32'h1);
        idle(1);
        take();
        doEret();
        idle(2);

        $display("[TB] events during SERVICE");
        writeReg(A_EN, 32'h80000009);
        pulseSrc(4'b0001);
        idle(3);
        take();
        pulseSrc(4'b1000);
        idle(3);
        checkConst("no_irq_in_service", 32'(irq), 32'h0);
        take();
        checkConst("take_ignored_service", 32'(in_service), 32'h1);
        doEret();
        idle(2);
        #1 checkConst("irq_src3_after_eret", 32'(irq), 32'h1);
        take();
        readConst("cause_src3", A_CAUSE, 32'h3);

        $display("[TB] reset in SERVICE");
        pulseSrc(4'b1111);
        idle(2);
        readConst("pend_all", A_PEND, 32'hF);
        #2;
        reset = 1; src = '0; irq_taken = 0; eret = 0; wr = 0; rd = 1; addr = A_PEND;
        #1;
        checkConst("rst_irq", 32'(irq), 32'h0);
        checkConst("rst_in_service", 32'(in_service), 32'h0);
        checkConst("rst_pend", rdata, 32'h0);
        addr = A_EN;
        #1 checkConst("rst_enable", rdata, 32'h0);
        addr = A_CAUSE;
        #1 checkConst("rst_cause", rdata, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 0; rd = 0;
        idle(5);
        checkConst("no_irq_after_reset", 32'(irq), 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic [NSRC-1:0] s;
            logic            w, r;
            logic [31:0]     a, d;
            s = ($urandom_range(0, 5) == 0) ? NSRC'($urandom) : '0;
            w = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 4))
                0: a = A_EN;
                1: a = A_PEND;
                2: a = A_CAUSE;
                3: a = BASE + 32'd12;
                default: a = $urandom;
            endcase
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[31] = 1'b1;
            applyStimulus(s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0), w, r, a, d);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
